// File: rtl/game_pkg.sv
// Shared constants for the sprite display path: directions, sprite IDs,
// colours, death-animation states and the position bundle.
package game_pkg;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    localparam logic [2:0] ID_NONE   = 3'd0;
    localparam logic [2:0] ID_PACMAN = 3'd1;
    localparam logic [2:0] ID_BLINKY = 3'd2;
    localparam logic [2:0] ID_PINKY  = 3'd3;
    localparam logic [2:0] ID_INKY   = 3'd4;
    localparam logic [2:0] ID_CLYDE  = 3'd5;

    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_PACMAN = 12'hFF0;
    localparam logic [11:0] COL_BLINKY = 12'hF00;
    localparam logic [11:0] COL_PINKY  = 12'hF8C;
    localparam logic [11:0] COL_INKY   = 12'h0FF;
    localparam logic [11:0] COL_CLYDE  = 12'hF80;

    typedef enum logic [1:0] {
        ANIM_ALIVE = 2'd0,
        ANIM_DYING = 2'd1,
        ANIM_DEAD  = 2'd2
    } anim_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } pos_t;

endpackage

// File: rtl/sprite_hit.sv
// Box hit test of one scan pixel against one sprite's top-left corner.
// Borrow on the subtraction means the pixel lies left/above: no wrap-around.
module sprite_hit
    import game_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int DXW      = $clog2(SPRITE_W),
    parameter int DYW      = $clog2(SPRITE_H)
) (
    input  logic [10:0]    pos_x,
    input  logic [9:0]     pos_y,
    input  logic [10:0]    hcount,
    input  logic [9:0]     vcount,
    output logic           hit,
    output logic [DXW-1:0] dx,
    output logic [DYW-1:0] dy
);

    logic [11:0] dx_full;
    logic [10:0] dy_full;

    assign dx_full = {1'b0, hcount} - {1'b0, pos_x};
    assign dy_full = {1'b0, vcount} - {1'b0, pos_y};

    assign hit = !dx_full[11] && (dx_full[10:0] < 11'(SPRITE_W))
              && !dy_full[10] && (dy_full[9:0] < 10'(SPRITE_H));

    assign dx = dx_full[DXW-1:0];
    assign dy = dy_full[DYW-1:0];

endmodule

// File: rtl/sprite_compositor.sv
// Per-frame sprite latch, 2-stage hit/priority pipeline and pacman death FSM.
// Optional feature macro: SPRITE_SHAPE_EN (round pacman with a mouth wedge).
module sprite_compositor
    import game_pkg::*;
#(
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int FLASH_FRAMES = 8,
    parameter int DYING_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    input  logic [10:0] blinky_pos_x,
    input  logic [9:0]  blinky_pos_y,
    input  logic [10:0] pinky_pos_x,
    input  logic [9:0]  pinky_pos_y,
    input  logic [10:0] inky_pos_x,
    input  logic [9:0]  inky_pos_y,
    input  logic [10:0] clyde_pos_x,
    input  logic [9:0]  clyde_pos_y,
    input  logic        pacman_is_dead,
    input  logic [3:0]  pacman_dir,
    output logic [11:0] rgb,
    output logic        rgb_valid,
    output logic [2:0]  sprite_id,
    output logic [1:0]  anim_state
);

    localparam int DXW = $clog2(SPRITE_W);
    localparam int DYW = $clog2(SPRITE_H);
    localparam int CW  = $clog2(DYING_FRAMES);

    pos_t [4:0]     in_pos;
    pos_t [4:0]     sh_pos;
    logic [3:0]     sh_dir;
    logic           sh_dead;
    anim_t          state;
    logic [CW-1:0]  frame_cnt;
    logic [4:0]     hit;
    logic [DXW-1:0] dx [5];
    logic [DYW-1:0] dy [5];
    logic           pac_vis;
    logic           pac_shape;
    logic           unused_ok;
    logic [4:0]     s1_hit;
    logic           s1_valid;
    logic [11:0]    rgb_n;
    logic [2:0]     id_n;

    assign in_pos[0] = '{x: pacman_pos_x, y: pacman_pos_y};
    assign in_pos[1] = '{x: blinky_pos_x, y: blinky_pos_y};
    assign in_pos[2] = '{x: pinky_pos_x,  y: pinky_pos_y};
    assign in_pos[3] = '{x: inky_pos_x,   y: inky_pos_y};
    assign in_pos[4] = '{x: clyde_pos_x,  y: clyde_pos_y};

    // Freeze game-logic outputs once per frame so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_pos  <= '0;
            sh_dir  <= '0;
            sh_dead <= 1'b0;
        end else if (frame_start) begin
            sh_pos  <= in_pos;
            sh_dir  <= pacman_dir;
            sh_dead <= pacman_is_dead;
        end
    end

    // Death animation: flash for DYING_FRAMES-1 frames, then stay hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ANIM_ALIVE;
            frame_cnt <= '0;
        end else if (frame_start) begin
            unique case (state)
                ANIM_ALIVE: begin
                    if (pacman_is_dead) begin
                        state     <= ANIM_DYING;
                        frame_cnt <= '0;
                    end
                end
                ANIM_DYING: begin
                    if (!pacman_is_dead) begin
                        state     <= ANIM_ALIVE;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (frame_cnt == CW'(DYING_FRAMES - 2))
                            state <= ANIM_DEAD;
                    end
                end
                ANIM_DEAD: begin
                    if (!pacman_is_dead) begin
                        state     <= ANIM_ALIVE;
                        frame_cnt <= '0;
                    end
                end
                default: begin
                    state     <= ANIM_ALIVE;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

    assign anim_state = state;

    assign pac_vis = (state == ANIM_ALIVE)
                  || ((state == ANIM_DYING)
                      && ((int'(frame_cnt) / FLASH_FRAMES) % 2 == 0));

    for (genvar i = 0; i < 5; i++) begin : g_hit
        sprite_hit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_hit (
            .pos_x  (sh_pos[i].x),
            .pos_y  (sh_pos[i].y),
            .hcount (hcount),
            .vcount (vcount),
            .hit    (hit[i]),
            .dx     (dx[i]),
            .dy     (dy[i])
        );
    end

`ifdef SPRITE_SHAPE_EN
    localparam logic signed [DXW:0] CX0 = (DXW + 1)'(SPRITE_W / 2);
    localparam logic signed [DYW:0] CY0 = (DYW + 1)'(SPRITE_H / 2);
    localparam logic [15:0] R2 = 16'((SPRITE_W / 2) * (SPRITE_W / 2));

    logic signed [DXW:0] cx;
    logic signed [DYW:0] cy;
    logic [DXW:0]        ax;
    logic [DYW:0]        ay;
    logic [15:0]         r2;
    logic                mouth;

    assign cx = $signed({1'b0, dx[0]}) - CX0;
    assign cy = $signed({1'b0, dy[0]}) - CY0;
    assign ax = cx[DXW] ? -cx : cx;
    assign ay = cy[DYW] ? -cy : cy;
    assign r2 = 16'(ax) * 16'(ax) + 16'(ay) * 16'(ay);

    // Mouth wedge opens on the side pacman is facing.
    always_comb begin
        mouth = 1'b0;
        case (sh_dir)
            DIR_RIGHT: mouth = !cx[DXW] && (cx != '0) && (16'(ay) < 16'(ax));
            DIR_LEFT:  mouth = cx[DXW] && (16'(ay) < 16'(ax));
            DIR_UP:    mouth = cy[DYW] && (16'(ax) < 16'(ay));
            DIR_DOWN:  mouth = !cy[DYW] && (cy != '0) && (16'(ax) < 16'(ay));
            default:   mouth = 1'b0;
        endcase
    end

    assign pac_shape = (r2 < R2) && !mouth;
    assign unused_ok = ^{dx[1], dx[2], dx[3], dx[4],
                         dy[1], dy[2], dy[3], dy[4], sh_dead};
`else
    assign pac_shape = 1'b1;
    assign unused_ok = ^{dx[0], dx[1], dx[2], dx[3], dx[4],
                         dy[0], dy[1], dy[2], dy[3], dy[4],
                         sh_dir, sh_dead};
`endif

    // S1: hit vector, hidden or off-shape pacman already masked out.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_hit   <= {hit[4:1], hit[0] & pac_vis & pac_shape}
                      & {5{pix_valid}};
            s1_valid <= pix_valid;
        end
    end

    // Fixed priority: pacman over the ghosts in ID order.
    always_comb begin
        rgb_n = COL_BG;
        id_n  = ID_NONE;
        case (1'b1)
            s1_hit[0]: begin rgb_n = COL_PACMAN; id_n = ID_PACMAN; end
            s1_hit[1]: begin rgb_n = COL_BLINKY; id_n = ID_BLINKY; end
            s1_hit[2]: begin rgb_n = COL_PINKY;  id_n = ID_PINKY;  end
            s1_hit[3]: begin rgb_n = COL_INKY;   id_n = ID_INKY;   end
            s1_hit[4]: begin rgb_n = COL_CLYDE;  id_n = ID_CLYDE;  end
            default:   begin rgb_n = COL_BG;     id_n = ID_NONE;   end
        endcase
    end

    // S2: registered pixel output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= '0;
            sprite_id <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= rgb_n;
            sprite_id <= id_n;
            rgb_valid <= s1_valid;
        end
    end

endmodule
